// File: rtl/pe_cell_seq_ctrl_if.sv
// Job-control and input-beat handshake bundle between the register block/upstream and the PE sequencer.
// The master drives config, start/abort and in_vld; the slave (sequencer) returns status and in_rdy.
interface pe_cell_seq_ctrl_if;
  logic [31:0] reg_set_cycle;
  logic [7:0]  reg_reuse;
  logic        start;
  logic        abort;
  logic        in_vld;
  logic        in_rdy;
  logic        set_en;
  logic        calc_en;
  logic [3:0]  pass_idx;
  logic        pass_last;
  logic        busy;
  logic        done;

  modport master (
    output reg_set_cycle, reg_reuse, start, abort, in_vld,
    input  in_rdy, set_en, calc_en, pass_idx, pass_last, busy, done
  );

  modport slave (
    input  reg_set_cycle, reg_reuse, start, abort, in_vld,
    output in_rdy, set_en, calc_en, pass_idx, pass_last, busy, done
  );
endinterface

// File: rtl/pe_cell_seq_ctrl.sv
// PE job sequencer: SET -> CALC passes -> DRAIN -> DONE; set_en from start+1, in_rdy after set_n cycles.
// in_rdy is high for the whole of CALC; in_vld=0 stalls the beat count indefinitely.
module pe_cell_seq_ctrl #(
  parameter int DRAIN_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pe_cell_seq_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_SET, S_CALC, S_DRAIN, S_DONE} state_e;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);

  state_e      state_q, state_d;
  logic [31:0] set_cnt_q, set_cnt_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]  pass_idx_q, pass_idx_d;
  logic [3:0]  pass_n_q, pass_n_d;
  logic [3:0]  beat_n_q, beat_n_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      set_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      pass_idx_q  <= '0;
      pass_n_q    <= '0;
      beat_n_q    <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      set_cnt_q   <= set_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      pass_idx_q  <= pass_idx_d;
      pass_n_q    <= pass_n_d;
      beat_n_q    <= beat_n_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_cnt_d   = set_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    pass_idx_d  = pass_idx_q;
    pass_n_d    = pass_n_q;
    beat_n_d    = beat_n_q;
    drain_cnt_d = drain_cnt_q;

    if (bus.abort) begin
      state_d     = S_IDLE;
      set_cnt_d   = '0;
      beat_cnt_d  = '0;
      pass_idx_d  = '0;
      pass_n_d    = '0;
      beat_n_d    = '0;
      drain_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            // Snapshot config so register rewrites mid-job cannot disturb this job
            set_cnt_d   = bus.reg_set_cycle;
            pass_n_d    = (bus.reg_reuse[3:0] == 4'd0) ? 4'd1 : bus.reg_reuse[3:0];
            beat_n_d    = (bus.reg_reuse[7:4] == 4'd0) ? 4'd1 : bus.reg_reuse[7:4];
            beat_cnt_d  = '0;
            pass_idx_d  = '0;
            drain_cnt_d = '0;
            state_d     = (bus.reg_set_cycle != 32'd0) ? S_SET : S_CALC;
          end
        end
        S_SET: begin
          if (set_cnt_q <= 32'd1) begin
            set_cnt_d = '0;
            state_d   = S_CALC;
          end else begin
            set_cnt_d = set_cnt_q - 32'd1;
          end
        end
        S_CALC: begin
          if (bus.in_vld) begin
            if (beat_cnt_q == beat_n_q - 4'd1) begin
              beat_cnt_d = '0;
              if (pass_idx_q == pass_n_q - 4'd1) begin
                pass_idx_d  = '0;
                drain_cnt_d = '0;
                state_d     = S_DRAIN;
              end else begin
                pass_idx_d = pass_idx_q + 4'd1;
              end
            end else begin
              beat_cnt_d = beat_cnt_q + 4'd1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            drain_cnt_d = '0;
            state_d     = S_DONE;
          end else begin
            drain_cnt_d = drain_cnt_q + 8'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.in_rdy    = (state_q == S_CALC);
  assign bus.set_en    = (state_q == S_SET);
  assign bus.calc_en   = bus.in_vld & (state_q == S_CALC);
  assign bus.pass_idx  = pass_idx_q;
  assign bus.pass_last = (state_q == S_CALC) && (pass_idx_q == pass_n_q - 4'd1);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_pe_cell_seq_ctrl.sv
// Randomized bench for pe_cell_seq_ctrl: a job-timeline model predicts set_en/calc_en/done events
// into a queue, and a negedge monitor pops and compares them against what the sequencer emits.
module tb_pe_cell_seq_ctrl;

  localparam int DRAIN_CYC = 4;
  localparam int EV_SET  = 0;
  localparam int EV_BEAT = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int cyc;
    int pidx;
    bit plast;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  pe_cell_seq_ctrl_if bus ();

  pe_cell_seq_ctrl #(.DRAIN_CYC(DRAIN_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void push_ev(input int kind, input int c, input int pidx, input bit plast);
    ev_t e;
    e.kind = kind; e.cyc = c; e.pidx = pidx; e.plast = plast;
    exp_q.push_back(e);
  endfunction

  task automatic mon_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d at cycle %0d: got event, expected none", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.cyc != cyc ||
        (kind == EV_BEAT && (e.pidx != int'(bus.pass_idx) || e.plast != bus.pass_last))) begin
      errors++;
      $display("FAIL event got kind=%0d cyc=%0d pidx=%0d plast=%0d expected kind=%0d cyc=%0d pidx=%0d plast=%0d",
               kind, cyc, bus.pass_idx, bus.pass_last, e.kind, e.cyc, e.pidx, e.plast);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.set_en)  mon_ev(EV_SET);
      if (bus.calc_en) mon_ev(EV_BEAT);
      if (bus.done)    mon_ev(EV_DONE);
    end
  end

  // kill_kind: 0 none, 1 abort, 2 reset, applied in the kill_at-th cycle after start
  task automatic run_job(input int sn, input logic [7:0] ru, input int kill_at,
                         input int kill_kind, input int vld_pct);
    int pn, bn, total, beats, qlast, ph;
    bit killed;
    pn = (ru[3:0] == 0) ? 1 : int'(ru[3:0]);
    bn = (ru[7:4] == 0) ? 1 : int'(ru[7:4]);
    total = pn * bn;
    beats = 0;
    qlast = 0;
    killed = 0;

    @(posedge clk); #1;
    chk("idle_busy_before_start", int'(bus.busy), 0);
    bus.reg_set_cycle = 32'(sn);
    bus.reg_reuse     = ru;
    bus.start         = 1'b1;
    bus.abort         = 1'b0;
    bus.in_vld        = ($urandom_range(1) == 1);

    for (int r = 1; r < 5000; r++) begin
      @(posedge clk); #1;
      bus.start         = ($urandom_range(4) == 0);
      bus.reg_set_cycle = 32'($urandom_range(7));
      bus.reg_reuse     = 8'($urandom_range(255));
      bus.in_vld        = ($urandom_range(99) < vld_pct);
      bus.abort         = 1'b0;

      if (r <= sn)              ph = EV_SET;
      else if (beats < total)   ph = EV_BEAT;
      else if (cyc <= qlast + DRAIN_CYC) ph = 3;
      else                      ph = EV_DONE;

      chk("in_rdy", int'(bus.in_rdy), int'(ph == EV_BEAT));
      chk("busy", int'(bus.busy), 1);

      if (r == kill_at && kill_kind == 2) begin
        rst_n = 1'b0;
        killed = 1;
        break;
      end
      if (r == kill_at && kill_kind == 1) begin
        bus.abort = 1'b1;
        killed = 1;
      end

      if (ph == EV_SET) push_ev(EV_SET, cyc, 0, 1'b0);
      else if (ph == EV_BEAT && bus.in_vld) begin
        push_ev(EV_BEAT, cyc, beats / bn, (beats / bn) == pn - 1);
        beats++;
        if (beats == total) qlast = cyc;
      end else if (ph == EV_DONE) push_ev(EV_DONE, cyc, 0, 1'b0);

      if (killed || ph == EV_DONE) break;
    end

    @(posedge clk); #1;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("idle_busy_after_job", int'(bus.busy), 0);
    chk("idle_in_rdy_after_job", int'(bus.in_rdy), 0);
    chk("idle_set_en_after_job", int'(bus.set_en), 0);
    chk("idle_done_after_job", int'(bus.done), 0);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.reg_set_cycle = 32'd0;
    bus.reg_reuse     = 8'd0;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.in_vld        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_set_en", int'(bus.set_en), 0);
    chk("rst_in_rdy", int'(bus.in_rdy), 0);
    chk("rst_calc_en", int'(bus.calc_en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_pass_idx", int'(bus.pass_idx), 0);
    chk("rst_pass_last", int'(bus.pass_last), 0);
    rst_n = 1'b1;
    bus.in_vld = 1'b0;
    repeat (2) @(posedge clk);

    run_job(2, 8'h61, 0, 0, 100);
    run_job(0, 8'h23, 0, 0, 100);
    run_job(3, 8'h00, 0, 0, 100);
    run_job(1, 8'h21, 0, 0, 50);
    run_job(5, 8'h22, 3, 1, 100);
    run_job(2, 8'h12, 0, 0, 100);
    run_job(1, 8'h33, 5, 1, 70);
    run_job(0, 8'h32, 0, 0, 60);
    run_job(2, 8'h42, 6, 2, 100);
    run_job(1, 8'h21, 0, 0, 100);

    // start and abort together in IDLE: abort wins
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.reg_set_cycle = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("start_abort_idle_busy", int'(bus.busy), 0);
      @(posedge clk); #1;
    end

    run_job(40, 8'h11, 0, 0, 100);

    for (int j = 0; j < 20; j++) begin
      run_job(int'($urandom_range(6)), 8'($urandom_range(255)), 0, 0,
              int'($urandom_range(100, 30)));
    end

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
